// File: rtl/csi2tx_defines.sv
// Shared constants for the CSI-2 TX pixel-to-byte stage: data-type codes,
// converter enable bit positions, sequencer state encoding and flush length.
package csi2tx_defines;

  localparam logic [5:0] DT_RAW8       = 6'h2A;
  localparam logic [5:0] DT_RAW10      = 6'h2B;
  localparam logic [5:0] DT_YUV422_8B  = 6'h1E;
  localparam logic [5:0] DT_YUV422_10B = 6'h1F;
  localparam logic [5:0] DT_RGB888     = 6'h24;

  localparam int EN_RAW8       = 0;
  localparam int EN_RAW10      = 1;
  localparam int EN_YUV422_8B  = 2;
  localparam int EN_YUV422_10B = 3;
  localparam int EN_RGB888     = 4;
  localparam int NUM_CONV      = 5;

  // Cycles spent after the last pixel so converters can push out a partial word.
  localparam int FLUSH_LEN   = 2;
  localparam int FLUSH_CNT_W = $clog2(FLUSH_LEN);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Map a CSI-2 data type to its converter enable; all-zero means unsupported.
  function automatic logic [NUM_CONV-1:0] dt_to_onehot(input logic [5:0] dt);
    logic [NUM_CONV-1:0] oh;
    oh = '0;
    case (dt)
      DT_RAW8:       oh[EN_RAW8]       = 1'b1;
      DT_RAW10:      oh[EN_RAW10]      = 1'b1;
      DT_YUV422_8B:  oh[EN_YUV422_8B]  = 1'b1;
      DT_YUV422_10B: oh[EN_YUV422_10B] = 1'b1;
      DT_RGB888:     oh[EN_RGB888]     = 1'b1;
      default:       oh                = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/csi2tx_p2b_dw_mux.sv
// One-hot 5:1 registered mux of converter words toward the packet builder,
// plus a saturating count of payload bytes emitted on the current line.
module csi2tx_p2b_dw_mux
  import csi2tx_defines::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [NUM_CONV-1:0]   conv_enable,
  input  logic [32*NUM_CONV-1:0] conv_dw,
  input  logic [NUM_CONV-1:0]   conv_dw_vld,
  output logic [31:0]           dw,
  output logic                  dw_vld,
  output logic [16:0]           byte_cnt
);

  localparam logic [16:0] BYTE_CNT_MAX = '1;

  logic [31:0] sel_dw;
  logic        sel_vld;

  // AND-OR select of the enabled converter; disabled converters contribute nothing.
  // With conv_enable cleared in IDLE, dw_vld naturally drops there except for the
  // word captured in DONE, which appears one cycle later as the line's last word.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    sel_dw  = '0;
    sel_vld = 1'b0;
    for (int k = 0; k < NUM_CONV; k++) begin
      if (conv_enable[k]) begin
        sel_dw  = sel_dw | conv_dw[32*k +: 32];
        sel_vld = sel_vld | conv_dw_vld[k];
      end
    end
  end

  // Output word register and byte counter; a new line clears the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      dw       <= '0;
      dw_vld   <= 1'b0;
      byte_cnt <= '0;
    end else begin
      dw     <= sel_dw;
      dw_vld <= sel_vld;
      if (clr) begin
        byte_cnt <= '0;
      end else if (sel_vld) begin
        byte_cnt <= (byte_cnt > BYTE_CNT_MAX - 17'd4) ? BYTE_CNT_MAX : byte_cnt + 17'd4;
      end
    end
  end

endmodule

// File: rtl/csi2tx_p2b_sched.sv
// Line-level sequencer for the CSI-2 TX pixel-to-byte stage: selects the
// format converter, registers the pixel stream and checks the line's byte count.
module csi2tx_p2b_sched
  import csi2tx_defines::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    line_start,
  input  logic [5:0]              data_type,
  input  logic [15:0]             word_count,
  input  logic                    sensor_pixel_vld,
  input  logic [31:0]             sensor_pixel_data,
  output logic [31:0]             pixel_data,
  output logic [31:0]             pixel_data_d1,
  output logic                    pixel_data_vld,
  output logic [2:0]              pixel_cnt,
  output logic                    sensor_pixel_vld_falling_edge,
  output logic [NUM_CONV-1:0]     conv_enable,
  input  logic [32*NUM_CONV-1:0]  conv_dw,
  input  logic [NUM_CONV-1:0]     conv_dw_vld,
  output logic [31:0]             dw,
  output logic                    dw_vld,
  output logic                    line_done,
  output logic                    wc_err,
  output logic                    dt_err,
  output logic                    line_abort
);

  state_t                  state, state_nxt;
  logic [FLUSH_CNT_W-1:0]  flush_cnt;
  logic [15:0]             wc_q;
  logic                    pixel_data_vld_q;
  logic [16:0]             byte_cnt;
  logic [NUM_CONV-1:0]     dt_onehot;
  logic [17:0]             wc_hi;
  logic                    wc_ok;

  assign dt_onehot = dt_to_onehot(data_type);
  // Accept up to 3 bytes of padding in the last word.
  assign wc_hi     = {2'b00, wc_q} + 18'd4;
  assign wc_ok     = ({1'b0, byte_cnt} >= {2'b00, wc_q}) && ({1'b0, byte_cnt} < wc_hi);

  // Pixel pipeline shared by all converters; runs regardless of line state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_data                    <= '0;
      pixel_data_d1                 <= '0;
      pixel_data_vld                <= 1'b0;
      pixel_data_vld_q              <= 1'b0;
      sensor_pixel_vld_falling_edge <= 1'b0;
    end else begin
      pixel_data                    <= sensor_pixel_data;
      pixel_data_d1                 <= pixel_data;
      pixel_data_vld                <= sensor_pixel_vld;
      pixel_data_vld_q              <= pixel_data_vld;
      sensor_pixel_vld_falling_edge <= pixel_data_vld_q & ~pixel_data_vld;
    end
  end

  // Pixel counter: cleared per line, advances only while the line is active,
  // and holds after the last pixel so converters can read the partial count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_cnt <= '0;
    end else if (line_start) begin
      pixel_cnt <= '0;
    end else if (state == ACTIVE && pixel_data_vld) begin
      pixel_cnt <= pixel_cnt + 3'd1;
    end
  end

  // Line setup: latch format and length on line_start, drop enable after DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_enable <= '0;
      wc_q        <= '0;
      dt_err      <= 1'b0;
      line_abort  <= 1'b0;
    end else begin
      dt_err     <= line_start & ~(|dt_onehot);
      line_abort <= line_start & (state != IDLE);
      if (line_start) begin
        conv_enable <= dt_onehot;
        wc_q        <= word_count;
      end else if (state == DONE) begin
        conv_enable <= '0;
      end
    end
  end

  // Sequencer state register and flush-length counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
    end
  end

  // Next state and end-of-line pulses; a line_start always restarts the line.
  always_comb begin
    state_nxt = state;
    line_done = 1'b0;
    wc_err    = 1'b0;
    if (line_start) begin
      state_nxt = (|dt_onehot) ? ACTIVE : IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        ACTIVE:  if (sensor_pixel_vld_falling_edge) state_nxt = FLUSH;
        FLUSH:   if (flush_cnt == FLUSH_LAST) state_nxt = DONE;
        DONE: begin
          line_done = 1'b1;
          wc_err    = ~wc_ok;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  csi2tx_p2b_dw_mux u_dw_mux (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (line_start),
    .conv_enable (conv_enable),
    .conv_dw     (conv_dw),
    .conv_dw_vld (conv_dw_vld),
    .dw          (dw),
    .dw_vld      (dw_vld),
    .byte_cnt    (byte_cnt)
  );

endmodule
